response_block_pe_ot: RTL and testbench
=======================================

RESPONSE_BLOCK_PE_OT -- requirements
Module: response_block_pe_ot

Interface
REQ-001 Parameter ID, default 1: PE index; data_ID_o carries a one-hot bit at this position.
REQ-002 Parameter ID_WIDTH, default 17: width of data_ID_o.
REQ-003 Parameter N_SLAVE, default 16: number of peripheral targets, 2..32.
REQ-004 Parameter DATA_WIDTH, default 32: response data width.
REQ-005 Parameter ADDR_WIDTH, default 32: request address width.
REQ-006 Parameters PE_ROUTING_LSB/MSB, defaults 16/19: address field selecting the target index.
REQ-007 Parameter MAX_OUTSTANDING, default 4: outstanding-transaction depth, 1..16.
REQ-008 Parameter ERR_RDATA, default 32'hBADACCE5: rdata returned on a decode miss.
REQ-009 Clocking: one clock; reset is synchronous and active-high.
REQ-010 clk  in  1  rising-edge clock.
REQ-011 rst  in  1  synchronous active-high reset.
REQ-012 data_req_i  in  1  master request.
REQ-013 data_add_i  in  ADDR_WIDTH  master address.
REQ-014 data_gnt_o  out  1  grant to master.
REQ-015 data_req_o  out  N_SLAVE  per-target request.
REQ-016 data_gnt_i  in  N_SLAVE  per-target grant.
REQ-017 data_ID_o  out  ID_WIDTH  constant one-hot requester ID.
REQ-018 data_r_valid_i / data_r_rdata_i / data_r_opc_i  in  N_SLAVE / N_SLAVE x DATA_WIDTH / N_SLAVE  per-target response.
REQ-019 data_r_valid_o / data_r_rdata_o / data_r_opc_o  out  1 / DATA_WIDTH / 1  response to master; opc=1 marks an error.
REQ-020 outstanding_o  out  clog2(MAX_OUTSTANDING+1)  current in-flight count.
REQ-021 proto_err_o  out  1  sticky protocol-violation flag.

Function
REQ-022 Decode: idx = data_add_i[MSB:LSB]; idx < N_SLAVE is a hit, otherwise a miss.
REQ-023 Hit: data_req_o[idx] = data_req_i & ~full; all other bits are 0; data_gnt_o = data_gnt_i[idx] & ~full.
REQ-024 Miss: data_req_o = 0; data_gnt_o = data_req_i & ~full, i.e. internal grant.
REQ-025 full = (count == MAX_OUTSTANDING); full blocks request and grant even when a pop occurs in the same cycle.
REQ-026 Every granted request pushes its target tag {miss, idx} into an in-order tracking FIFO of depth MAX_OUTSTANDING.
REQ-027 Hit head: when data_r_valid_i[head.idx]=1, pop and register rdata/opc; data_r_valid_o=1 the next cycle (latency 1).
REQ-028 Miss head: pop in the cycle it is head and register rdata=ERR_RDATA, opc=1; this gives valid 2 cycles after a grant into an empty FIFO.
REQ-029 Only one pop per cycle; data_r_valid_o is 0 in cycles with no pop.
REQ-030 data_r_valid_i[k]=1 for k != head.idx, or any valid while the FIFO is empty: set proto_err_o, drop the response, leave the FIFO unchanged.
REQ-031 Push and pop in the same cycle: count unchanged; pointers wrap modulo MAX_OUTSTANDING.
REQ-032 The master holds req and add until granted; the block does not register requests (grant is combinational).

Reset
REQ-033 rst=1 at a clock edge clears FIFO pointers, count, proto_err_o and the output registers (valid/opc=0, rdata=0).
REQ-034 Reset mid-operation discards in-flight tags; responses arriving after reset fall under REQ-030.
REQ-035 data_req_o and data_gnt_o stay combinational during reset; full=0 after reset.

Structure
REQ-036 Shared package peripheral_interco_pkg holds the tag typedef {miss, idx} and the ERR_RDATA default.
REQ-037 The tracking FIFO is sub-module resp_tag_fifo (push, pop, full, empty, head, count).

Verification
REQ-038 Hit: add idx=3, data_gnt_i[3]=1 at t0, data_r_valid_i[3] with rdata 0x1234 at t2 -> data_r_valid_o=1, rdata=0x1234, opc=0 at t3.
REQ-039 Miss: N_SLAVE=8, idx=12 granted at t0 -> data_r_valid_o=1, rdata=0xBADACCE5, opc=1 at t2; data_req_o=0 throughout.
REQ-040 Full: MAX_OUTSTANDING=4, four grants with no responses -> outstanding_o=4; a fifth request sees gnt=0 and req_o=0 even if a pop occurs the same cycle.
REQ-041 Ordering: grants to 2, 5, miss; responses from 5 then 2 -> proto_err_o=1 on the first; then 2 is returned, 5 re-sent is returned, then the error response.
REQ-042 Simultaneous push/pop at count=2 -> count stays 2; 20 wrap-around transactions return in order.
REQ-043 Reset with 3 outstanding -> count=0 and valid=0 the next cycle; a late data_r_valid_i sets proto_err_o.

Source files
------------

// File: rtl/peripheral_interco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_interco_pkg
// Description : Shared types for the peripheral interconnect response path.
//               Holds the response tag {miss, idx} carried by the in-order
//               tracking FIFO and the default error read data.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_interco_pkg;

  // Tag index width covers the largest supported target count (32).
  localparam int unsigned TAG_IDX_W = 5;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

  // miss=1 marks a decode miss: no target will respond, the block answers
  // on its own with an error response.
  typedef struct packed {
    logic                 miss;
    logic [TAG_IDX_W-1:0] idx;
  } resp_tag_t;

endpackage
`default_nettype wire

// File: rtl/resp_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_tag_fifo
// Description : In-order tracking FIFO of response tags for outstanding
//               transactions.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               push_i/tag_i - enqueue a tag (ignored when full)
//               pop_i        - dequeue the head (ignored when empty)
//               full_o/empty_o, head_o, count_o - status and head tag
// Revision    : 1.0 - initial release
// ============================================================================
module resp_tag_fifo
  import peripheral_interco_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  resp_tag_t        tag_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output resp_tag_t        head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_tag_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/response_block_pe_ot.sv
`default_nettype none
// ============================================================================
// Module      : response_block_pe_ot
// Description : Routes one master's requests to N_SLAVE peripheral targets by
//               address decode and returns responses strictly in order, with
//               up to MAX_OUTSTANDING transactions in flight. Decode misses
//               are granted internally and answered with an error response.
// Ports       : clk, rst                       - clock, sync active-high reset
//               data_req_i/data_add_i/data_gnt_o - master request channel
//               data_req_o/data_gnt_i          - per-target request channel
//               data_ID_o                      - constant one-hot requester ID
//               data_r_*_i                     - per-target response channel
//               data_r_*_o                     - response to master (opc=1 error)
//               outstanding_o                  - in-flight transaction count
//               proto_err_o                    - sticky protocol violation
// Revision    : 1.0 - initial release
// ============================================================================
module response_block_pe_ot
  import peripheral_interco_pkg::*;
#(
  parameter int unsigned            ID              = 1,
  parameter int unsigned            ID_WIDTH        = 17,
  parameter int unsigned            N_SLAVE         = 16,
  parameter int unsigned            DATA_WIDTH      = 32,
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            PE_ROUTING_LSB  = 16,
  parameter int unsigned            PE_ROUTING_MSB  = 19,
  parameter int unsigned            MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0]  ERR_RDATA       = DATA_WIDTH'(ERR_RDATA_DEFAULT),
  localparam int unsigned           CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_req_i,
  input  logic [ADDR_WIDTH-1:0]         data_add_i,
  output logic                          data_gnt_o,
  output logic [N_SLAVE-1:0]            data_req_o,
  input  logic [N_SLAVE-1:0]            data_gnt_i,
  output logic [ID_WIDTH-1:0]           data_ID_o,
  input  logic [N_SLAVE-1:0]            data_r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic [N_SLAVE-1:0]            data_r_opc_i,
  output logic                          data_r_valid_o,
  output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
  output logic                          data_r_opc_o,
  output logic [CNT_W-1:0]              outstanding_o,
  output logic                          proto_err_o
);

  localparam int unsigned FIELD_W = PE_ROUTING_MSB - PE_ROUTING_LSB + 1;

  logic [FIELD_W-1:0]    route_field;
  logic [N_SLAVE-1:0]    dec_onehot;
  logic                  dec_hit;
  logic                  accept;
  logic                  push;
  resp_tag_t             push_tag;
  logic                  fifo_full, fifo_empty;
  resp_tag_t             head;
  logic [N_SLAVE-1:0]    head_onehot;
  logic                  pop_hit, pop_miss, pop, stray;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_opc;
  logic                  addr_unused;

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  opc_q;
  logic                  proto_err_q;

  assign data_ID_o   = ID_WIDTH'(1) << ID;
  assign addr_unused = ^data_add_i;

  // ---------------------------------------------------------------- decode
  assign route_field = data_add_i[PE_ROUTING_MSB:PE_ROUTING_LSB];

  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      dec_onehot[k] = (32'(route_field) == 32'(k));
    end
  end

  // A field value at or above N_SLAVE matches no bit: that is the miss case.
  assign dec_hit = |dec_onehot;

  // Full blocks new traffic even if a pop frees a slot in the same cycle,
  // which keeps the grant path independent of the response path.
  assign accept     = data_req_i & ~fifo_full;
  assign data_req_o = dec_onehot & {N_SLAVE{accept}};
  assign data_gnt_o = dec_hit ? (|(data_gnt_i & dec_onehot)) & ~fifo_full
                              : accept;

  assign push          = data_req_i & data_gnt_o;
  assign push_tag.miss = ~dec_hit;
  assign push_tag.idx  = TAG_IDX_W'(route_field);

  // ------------------------------------------------------------- tracking
  resp_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .tag_i   (push_tag),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head),
    .count_o (outstanding_o)
  );

  // Only the target named by a hit head may respond; every other valid is
  // a stray response (including any valid while empty or while a miss heads).
  always_comb begin
    head_onehot = '0;
    sel_rdata   = '0;
    sel_opc     = 1'b0;
    for (int k = 0; k < N_SLAVE; k++) begin
      head_onehot[k] = ~fifo_empty & ~head.miss & (head.idx == TAG_IDX_W'(k));
      if (head_onehot[k]) begin
        sel_rdata = data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_opc   = data_r_opc_i[k];
      end
    end
  end

  assign pop_hit  = |(data_r_valid_i & head_onehot);
  assign pop_miss = ~fifo_empty & head.miss;
  assign pop      = pop_hit | pop_miss;
  assign stray    = |(data_r_valid_i & ~head_onehot);

  // ------------------------------------------------------ response output
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      opc_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      valid_q     <= pop;
      proto_err_q <= proto_err_q | stray;
      if (pop_hit) begin
        rdata_q <= sel_rdata;
        opc_q   <= sel_opc;
      end else if (pop_miss) begin
        rdata_q <= ERR_RDATA;
        opc_q   <= 1'b1;
      end
    end
  end

  assign data_r_valid_o = valid_q;
  assign data_r_rdata_o = rdata_q;
  assign data_r_opc_o   = opc_q;
  assign proto_err_o    = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_response_block_pe_ot.sv
`default_nettype none
// ============================================================================
// Module      : tb_response_block_pe_ot
// Description : Self-checking bench for response_block_pe_ot (N_SLAVE=8,
//               MAX_OUTSTANDING=4). A queue-based reference model predicts
//               grants, target requests and the in-order response stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_response_block_pe_ot;

  localparam int          NS  = 8;
  localparam int          MO  = 4;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [31:0]   add;
  logic          gnt_o;
  logic [NS-1:0] req_o;
  logic [NS-1:0] gnt_i;
  logic [16:0]   id_o;
  logic [NS-1:0] rv_i;
  logic [NS*32-1:0] rdata_i;
  logic [NS-1:0] opc_i;
  logic          rv_o;
  logic [31:0]   rdata_o;
  logic          opc_o;
  logic [2:0]    outst;
  logic          perr;

  response_block_pe_ot #(
    .N_SLAVE         (NS),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_req_i     (req),
    .data_add_i     (add),
    .data_gnt_o     (gnt_o),
    .data_req_o     (req_o),
    .data_gnt_i     (gnt_i),
    .data_ID_o      (id_o),
    .data_r_valid_i (rv_i),
    .data_r_rdata_i (rdata_i),
    .data_r_opc_i   (opc_i),
    .data_r_valid_o (rv_o),
    .data_r_rdata_o (rdata_o),
    .data_r_opc_o   (opc_o),
    .outstanding_o  (outst),
    .proto_err_o    (perr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of target indices in grant order, -1 for a miss.
  int          q[$];
  bit          m_valid;
  logic [31:0] m_rdata;
  bit          m_opc;
  bit          m_perr;
  bit          m_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req   = 1'b0;
    gnt_i = '0;
    rv_i  = '0;
    opc_i = '0;
  endtask

  task automatic set_addr(input int idx);
    add        = $urandom;
    add[19:16] = 4'(idx);
  endtask

  task automatic set_resp(input int k, input logic [31:0] d, input bit e);
    rv_i[k]          = 1'b1;
    rdata_i[k*32 +: 32] = d;
    opc_i[k]         = e;
  endtask

  // One clock: check combinational outputs, advance the model, clock the
  // DUT, then check registered outputs.
  task automatic tick();
    int   idx;
    bit   hit;
    bit   full;
    int   head;
    logic [NS-1:0] e_req;
    #1;
    idx   = int'(add[19:16]);
    hit   = (idx < NS);
    full  = (q.size() == MO);
    m_gnt = full ? 1'b0 : (hit ? gnt_i[idx] : req);
    e_req = (hit && req && !full) ? (NS'(1) << idx) : '0;
    chk("gnt_o", 64'(gnt_o), 64'(m_gnt));
    chk("req_o", 64'(req_o), 64'(e_req));
    if (rst) begin
      q.delete();
      m_valid = 0; m_rdata = '0; m_opc = 0; m_perr = 0;
    end else begin
      m_valid = 0;
      head = (q.size() > 0) ? q[0] : -2;
      for (int k = 0; k < NS; k++) if (rv_i[k] && k != head) m_perr = 1;
      if (head == -1) begin
        void'(q.pop_front());
        m_valid = 1; m_rdata = ERR; m_opc = 1;
      end else if (head >= 0 && rv_i[head]) begin
        void'(q.pop_front());
        m_valid = 1; m_rdata = rdata_i[head*32 +: 32]; m_opc = opc_i[head];
      end
      if (req && m_gnt) q.push_back(hit ? idx : -1);
    end
    @(posedge clk);
    #1;
    chk("r_valid", 64'(rv_o), 64'(m_valid));
    chk("r_rdata", 64'(rdata_o), 64'(m_rdata));
    chk("r_opc", 64'(opc_o), 64'(m_opc));
    chk("outstanding", 64'(outst), 64'(q.size()));
    chk("proto_err", 64'(perr), 64'(m_perr));
  endtask

  initial begin
    bit pending;
    idle();
    rdata_i = '0;
    add     = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("data_ID", 64'(id_o), 64'h2);
    chk("reset_outstanding", 64'(outst), 64'd0);

    // Hit to target 3, response two cycles later.
    req = 1; set_addr(3); gnt_i = 8'h08; tick();
    idle(); tick();
    set_resp(3, 32'h1234, 0); tick();
    chk("hit_valid", 64'(rv_o), 64'd1);
    chk("hit_rdata", 64'(rdata_o), 64'h1234);
    chk("hit_opc", 64'(opc_o), 64'd0);
    idle(); tick();

    // Decode miss (field 12 >= 8): internal grant, error response.
    req = 1; set_addr(12); #1;
    chk("miss_req_o", 64'(req_o), 64'd0);
    tick();
    idle(); tick();
    chk("miss_rdata", 64'(rdata_o), 64'(ERR));
    chk("miss_opc", 64'(opc_o), 64'd1);
    idle(); tick();

    // Fill to MAX_OUTSTANDING, then request while a pop happens.
    for (int i = 0; i < MO; i++) begin
      req = 1; set_addr(1); gnt_i = 8'h02; tick();
    end
    chk("full_count", 64'(outst), 64'd4);
    set_resp(1, 32'hA5A5_0001, 0); #1;
    chk("full_gnt", 64'(gnt_o), 64'd0);
    chk("full_req_o", 64'(req_o), 64'd0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      rv_i = '0; set_resp(1, 32'h100 + i, 0); tick();
    end
    idle(); tick();

    // Ordering: grants to 2, 5, miss; 5 answers first (stray).
    req = 1; gnt_i = 8'hFF;
    set_addr(2); tick();
    set_addr(5); tick();
    set_addr(9); tick();
    idle(); set_resp(5, 32'h5555, 0); tick();
    chk("order_perr", 64'(perr), 64'd1);
    idle(); set_resp(2, 32'h2222, 0); tick();
    chk("order_first", 64'(rdata_o), 64'h2222);
    idle(); set_resp(5, 32'h5555, 1); tick();
    chk("order_second", 64'(rdata_o), 64'h5555);
    idle(); tick();
    chk("order_third", 64'(rdata_o), 64'(ERR));
    idle(); tick();

    // Reset clears the sticky flag, then simultaneous push/pop at count 2.
    rst = 1; tick(); rst = 0;
    req = 1; gnt_i = 8'h10; set_addr(4); tick(); tick();
    set_resp(4, 32'hC0DE, 0); tick();
    chk("pushpop_count", 64'(outst), 64'd2);
    idle();
    for (int i = 0; i < 20; i++) begin
      req = 1; set_addr(i % 2 == 0 ? 4 : 6); gnt_i = 8'h50;
      rv_i = '0;
      if (q.size() > 0 && q[0] >= 0) set_resp(q[0], 32'hD000 + i, i[0]);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rv_i = '0;
      if (q.size() > 0 && q[0] >= 0) set_resp(q[0], 32'hE000 + i, 0);
      tick();
    end
    idle(); tick();

    // Reset with three outstanding, then a late response.
    req = 1; gnt_i = 8'h01; set_addr(0); tick(); tick(); tick();
    idle();
    chk("pre_rst_count", 64'(outst), 64'd3);
    rst = 1; tick(); rst = 0;
    chk("rst_count", 64'(outst), 64'd0);
    chk("rst_valid", 64'(rv_o), 64'd0);
    set_resp(0, 32'hDEAD, 0); tick();
    chk("late_perr", 64'(perr), 64'd1);
    idle();
    rst = 1; tick(); rst = 0;

    // Randomized traffic; the master holds req/add until granted.
    pending = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && ($urandom_range(0, 99) < 60)) begin
        pending = 1;
        req = 1;
        set_addr($urandom_range(0, 11));
      end
      gnt_i = NS'($urandom);
      rv_i  = '0;
      opc_i = '0;
      if (q.size() > 0 && q[0] >= 0 && $urandom_range(0, 99) < 65)
        set_resp(q[0], $urandom, 1'($urandom));
      if ($urandom_range(0, 99) < 3)
        set_resp($urandom_range(0, NS - 1), $urandom, 0);
      tick();
      if (pending && m_gnt) begin
        pending = 0;
        req = 0;
      end
    end
    idle();
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
